// File: rtl/gtx_comma_align.sv
// K28.5 word aligner with lock hysteresis between the GTX 20-bit receive path and gtx_10x8dec.
// Define GTX_COMMA_ALIGN_STATS_EN to add the saturating relock_count output.
//
// state    | meaning
// UNLOCKED | no trusted offset; first comma found picks the offset
// VERIFY   | counting consecutive commas at the candidate offset
// LOCKED   | offset frozen; counting consecutive foreign commas
module gtx_comma_align #(
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] indata,
  output logic [19:0] outdata,
  output logic        aligned,
  output logic        comma,
  output logic        realign,
  output logic [4:0]  offset
`ifdef GTX_COMMA_ALIGN_STATS_EN
  ,
  output logic [15:0] relock_count
`endif
);

  localparam logic [9:0] K28_5_NEG = 10'h17C;
  localparam logic [9:0] K28_5_POS = 10'h283;
  localparam logic [3:0] LOCK_TC   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_TC = 4'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    VERIFY   = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [4:0]  offset_n;
  logic [19:0] prev;
  logic [39:0] win;
  logic [19:0] hit;
  logic        hit_any;
  logic        hit_cur;
  logic [4:0]  k_min;
  logic [19:0] sel;

  // Older word sits in the low half so bit order matches wire order.
  assign win = {indata, prev};

  for (genvar k = 0; k < 20; k++) begin : g_hit
    assign hit[k] = (win[k +: 10] == K28_5_NEG) || (win[k +: 10] == K28_5_POS);
  end

  assign hit_any = |hit;
  assign hit_cur = hit[offset];

  always_comb begin
    k_min = 5'd0;
    for (int k = 19; k >= 0; k--) begin
      if (hit[k]) k_min = 5'(k);
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    offset_n = offset;
    unique case (state)
      UNLOCKED: begin
        if (hit_any) begin
          offset_n = k_min;
          if (LOCK_TC <= 4'd1) begin
            state_n = LOCKED;
            cnt_n   = 4'd0;
          end else begin
            state_n = VERIFY;
            cnt_n   = 4'd1;
          end
        end
      end
      VERIFY: begin
        if (hit_cur) begin
          if (cnt + 4'd1 >= LOCK_TC) begin
            state_n = LOCKED;
            cnt_n   = 4'd0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end else if (hit_any) begin
          offset_n = k_min;
          cnt_n    = 4'd1;
        end
      end
      LOCKED: begin
        // Comma at the locked offset always wins over a foreign one.
        if (hit_cur) begin
          cnt_n = 4'd0;
        end else if (hit_any) begin
          if (cnt + 4'd1 >= UNLOCK_TC) begin
            state_n = UNLOCKED;
            cnt_n   = 4'd0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      default: begin
        state_n = UNLOCKED;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // Selecting with the next offset outputs the realigning word already aligned.
  assign sel = win[offset_n +: 20];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= UNLOCKED;
      cnt     <= 4'd0;
      offset  <= 5'd0;
      prev    <= 20'd0;
      outdata <= 20'd0;
      comma   <= 1'b0;
      aligned <= 1'b0;
      realign <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      offset  <= offset_n;
      prev    <= indata;
      outdata <= sel;
      comma   <= (sel[9:0] == K28_5_NEG) || (sel[9:0] == K28_5_POS);
      aligned <= (state_n == LOCKED);
      realign <= (offset_n != offset);
    end
  end

`ifdef GTX_COMMA_ALIGN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      relock_count <= 16'd0;
    end else if (state == LOCKED && state_n == UNLOCKED && relock_count != 16'hFFFF) begin
      relock_count <= relock_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gtx_comma_align.sv
// Directed bench for gtx_comma_align: builds serial-order bit streams of ALIGN
// primitives and checks lock, hysteresis, slip, reset and restart behaviour.
module tb_gtx_comma_align;

  localparam logic [9:0] K_NEG  = 10'h17C;
  localparam logic [9:0] K_POS  = 10'h283;
  localparam logic [9:0] D_10_2 = 10'h2AA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] indata = 20'd0;
  logic [19:0] outdata;
  logic        aligned;
  logic        comma;
  logic        realign;
  logic [4:0]  offset;
`ifdef GTX_COMMA_ALIGN_STATS_EN
  logic [15:0] relock_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int nstep = -1;
  int realign_seen = 0;
  bit sq[$];
  bit pol = 1'b0;

  always #5 clk = ~clk;

  gtx_comma_align dut (
    .clk     (clk),
    .rst     (rst),
    .indata  (indata),
    .outdata (outdata),
    .aligned (aligned),
    .comma   (comma),
    .realign (realign),
    .offset  (offset)
`ifdef GTX_COMMA_ALIGN_STATS_EN
    ,
    .relock_count (relock_count)
`endif
  );

  task automatic put_char(input logic [9:0] c);
    for (int j = 0; j < 10; j++) sq.push_back(c[j]);
  endtask

  task automatic put_zeros(input int n);
    for (int j = 0; j < n; j++) sq.push_back(1'b0);
  endtask

  task automatic put_alt(input int n);
    for (int j = 0; j < n; j++) sq.push_back(bit'(j % 2));
  endtask

  // ALIGN primitive: K28.5 (alternating disparity) then three D10.2.
  task automatic put_prims(input int n);
    for (int i = 0; i < n; i++) begin
      put_char(pol ? K_POS : K_NEG);
      pol = ~pol;
      put_char(D_10_2);
      put_char(D_10_2);
      put_char(D_10_2);
    end
  endtask

  // 40-bit block with no comma at the stream phase, one comma 16 bits in.
  task automatic put_false();
    put_char(D_10_2);
    put_alt(6);
    put_char(K_NEG);
    put_alt(14);
  endtask

  task automatic step();
    logic [19:0] w;
    for (int j = 0; j < 20; j++) begin
      if (sq.size() > 0) w[j] = sq.pop_front();
      else               w[j] = 1'b0;
    end
    indata = w;
    @(posedge clk);
    #1;
    nstep++;
    if (realign) realign_seen++;
  endtask

  task automatic run_to(input int n);
    while (nstep < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    indata = 20'd0;
    sq.delete();
    pol = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    nstep = -1;
    realign_seen = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (outdata !== 20'd0) begin miscompares++; $display("FAIL reset_outdata: got %h want 00000", outdata); end
    vectors++; if (aligned !== 1'b0) begin miscompares++; $display("FAIL reset_aligned: got %b want 0", aligned); end
    vectors++; if (comma !== 1'b0) begin miscompares++; $display("FAIL reset_comma: got %b want 0", comma); end
    vectors++; if (realign !== 1'b0) begin miscompares++; $display("FAIL reset_realign: got %b want 0", realign); end
    vectors++; if (offset !== 5'd0) begin miscompares++; $display("FAIL reset_offset: got %0d want 0", offset); end
`ifdef GTX_COMMA_ALIGN_STATS_EN
    vectors++; if (relock_count !== 16'd0) begin miscompares++; $display("FAIL reset_relock_count: got %0d want 0", relock_count); end
`endif
  endtask

  task automatic test_clean_lock();
    do_reset();
    put_zeros(7);
    put_prims(8);
    run_to(1);
    vectors++; if (realign !== 1'b1) begin miscompares++; $display("FAIL clean_realign_s1: got %b want 1", realign); end
    vectors++; if (offset !== 5'd7) begin miscompares++; $display("FAIL clean_offset_s1: got %0d want 7", offset); end
    vectors++; if (outdata !== 20'hAA97C) begin miscompares++; $display("FAIL clean_outdata_s1: got %h want aa97c", outdata); end
    vectors++; if (comma !== 1'b1) begin miscompares++; $display("FAIL clean_comma_s1: got %b want 1", comma); end
    vectors++; if (aligned !== 1'b0) begin miscompares++; $display("FAIL clean_aligned_s1: got %b want 0", aligned); end
    run_to(2);
    vectors++; if (comma !== 1'b0) begin miscompares++; $display("FAIL clean_comma_s2: got %b want 0", comma); end
    run_to(3);
    vectors++; if (outdata[9:0] !== K_POS || comma !== 1'b1) begin miscompares++; $display("FAIL clean_pos_comma_s3: got %h/%b want 283/1", outdata[9:0], comma); end
    run_to(5);
    vectors++; if (aligned !== 1'b0) begin miscompares++; $display("FAIL clean_aligned_s5: got %b want 0", aligned); end
    run_to(7);
    vectors++; if (aligned !== 1'b1) begin miscompares++; $display("FAIL clean_aligned_s7: got %b want 1", aligned); end
    run_to(8);
    vectors++; if (comma !== 1'b0) begin miscompares++; $display("FAIL clean_comma_s8: got %b want 0", comma); end
    run_to(9);
    vectors++; if (outdata[9:0] !== K_NEG || comma !== 1'b1) begin miscompares++; $display("FAIL clean_neg_comma_s9: got %h/%b want 17c/1", outdata[9:0], comma); end
    run_to(12);
    vectors++; if (realign_seen !== 1) begin miscompares++; $display("FAIL clean_realign_count: got %0d want 1", realign_seen); end
    vectors++; if (offset !== 5'd7) begin miscompares++; $display("FAIL clean_offset_end: got %0d want 7", offset); end
  endtask

  task automatic test_offset_wrap();
    int shifts[3] = '{0, 19, 10};
    logic [9:0] lo, hi;
    bit ok;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      put_zeros(shifts[t]);
      put_prims(10);
      run_to(5);
      vectors++; if (aligned !== 1'b0) begin miscompares++; $display("FAIL wrap%0d_aligned_s5: got %b want 0", shifts[t], aligned); end
      run_to(7);
      vectors++; if (aligned !== 1'b1) begin miscompares++; $display("FAIL wrap%0d_aligned_s7: got %b want 1", shifts[t], aligned); end
      vectors++; if (offset !== 5'(shifts[t])) begin miscompares++; $display("FAIL wrap%0d_offset: got %0d want %0d", shifts[t], offset, shifts[t]); end
      for (int s = 7; s <= 12; s++) begin
        run_to(s);
        lo = outdata[9:0];
        hi = outdata[19:10];
        ok = (lo == K_NEG || lo == K_POS || lo == D_10_2) && (hi == K_NEG || hi == K_POS || hi == D_10_2);
        vectors++; if (!ok) begin miscompares++; $display("FAIL wrap%0d_symbols_s%0d: got %h not a valid character pair", shifts[t], s, outdata); end
      end
    end
  endtask

  task automatic test_false_comma();
    do_reset();
    put_zeros(7);
    put_prims(4);
    put_false(); put_false(); put_false();
    put_prims(1);
    put_false(); put_false(); put_false(); put_false();
    run_to(7);
    vectors++; if (aligned !== 1'b1) begin miscompares++; $display("FAIL false_locked_s7: got %b want 1", aligned); end
    run_to(10);
    vectors++; if (aligned !== 1'b1 || offset !== 5'd7) begin miscompares++; $display("FAIL false_hold_s10: got %b/%0d want 1/7", aligned, offset); end
    vectors++; if (comma !== 1'b0) begin miscompares++; $display("FAIL false_comma_flag_s10: got %b want 0", comma); end
    run_to(14);
    vectors++; if (aligned !== 1'b1) begin miscompares++; $display("FAIL false_hold_s14: got %b want 1", aligned); end
    run_to(15);
    vectors++; if (comma !== 1'b1 || offset !== 5'd7) begin miscompares++; $display("FAIL false_real_comma_s15: got %b/%0d want 1/7", comma, offset); end
    run_to(18);
    vectors++; if (aligned !== 1'b1) begin miscompares++; $display("FAIL false_cnt_cleared_s18: got %b want 1", aligned); end
    run_to(22);
    vectors++; if (aligned !== 1'b1) begin miscompares++; $display("FAIL false_hold_s22: got %b want 1", aligned); end
    run_to(24);
    vectors++; if (aligned !== 1'b0 || offset !== 5'd7) begin miscompares++; $display("FAIL false_unlock_s24: got %b/%0d want 0/7", aligned, offset); end
    vectors++; if (realign_seen !== 1) begin miscompares++; $display("FAIL false_realign_count: got %0d want 1", realign_seen); end
  endtask

  task automatic test_slip();
    int base;
    do_reset();
    put_zeros(7);
    put_prims(4);
    put_zeros(1);
    put_prims(8);
    run_to(7);
    base = realign_seen;
    vectors++; if (aligned !== 1'b1) begin miscompares++; $display("FAIL slip_locked_s7: got %b want 1", aligned); end
    run_to(13);
    vectors++; if (aligned !== 1'b1 || offset !== 5'd7) begin miscompares++; $display("FAIL slip_hold_s13: got %b/%0d want 1/7", aligned, offset); end
    run_to(15);
    vectors++; if (aligned !== 1'b0 || offset !== 5'd7 || realign !== 1'b0) begin miscompares++; $display("FAIL slip_unlock_s15: got %b/%0d/%b want 0/7/0", aligned, offset, realign); end
    run_to(17);
    vectors++; if (realign !== 1'b1 || offset !== 5'd8 || aligned !== 1'b0) begin miscompares++; $display("FAIL slip_realign_s17: got %b/%0d/%b want 1/8/0", realign, offset, aligned); end
    run_to(21);
    vectors++; if (aligned !== 1'b0) begin miscompares++; $display("FAIL slip_verify_s21: got %b want 0", aligned); end
    run_to(23);
    vectors++; if (aligned !== 1'b1 || offset !== 5'd8) begin miscompares++; $display("FAIL slip_relock_s23: got %b/%0d want 1/8", aligned, offset); end
    vectors++; if (realign_seen - base !== 1) begin miscompares++; $display("FAIL slip_realign_count: got %0d want 1", realign_seen - base); end
`ifdef GTX_COMMA_ALIGN_STATS_EN
    vectors++; if (relock_count !== 16'd1) begin miscompares++; $display("FAIL slip_relock_count: got %0d want 1", relock_count); end
`endif
  endtask

  task automatic test_reset_midlock();
    do_reset();
    put_zeros(7);
    put_prims(12);
    run_to(9);
    vectors++; if (aligned !== 1'b1) begin miscompares++; $display("FAIL midrst_locked_s9: got %b want 1", aligned); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++; if (outdata !== 20'd0 || comma !== 1'b0) begin miscompares++; $display("FAIL midrst_data: got %h/%b want 00000/0", outdata, comma); end
    vectors++; if (aligned !== 1'b0 || realign !== 1'b0 || offset !== 5'd0) begin miscompares++; $display("FAIL midrst_ctrl: got %b/%b/%0d want 0/0/0", aligned, realign, offset); end
    run_to(13);
    vectors++; if (realign !== 1'b1 || offset !== 5'd7 || aligned !== 1'b0) begin miscompares++; $display("FAIL midrst_realign_s13: got %b/%0d/%b want 1/7/0", realign, offset, aligned); end
    run_to(17);
    vectors++; if (aligned !== 1'b0) begin miscompares++; $display("FAIL midrst_verify_s17: got %b want 0", aligned); end
    run_to(19);
    vectors++; if (aligned !== 1'b1) begin miscompares++; $display("FAIL midrst_relock_s19: got %b want 1", aligned); end
`ifdef GTX_COMMA_ALIGN_STATS_EN
    vectors++; if (relock_count !== 16'd0) begin miscompares++; $display("FAIL midrst_relock_count: got %0d want 0", relock_count); end
`endif
  endtask

  task automatic test_verify_restart();
    do_reset();
    put_zeros(5);
    put_prims(2);
    put_zeros(7);
    put_prims(6);
    run_to(1);
    vectors++; if (realign !== 1'b1 || offset !== 5'd5) begin miscompares++; $display("FAIL restart_first_s1: got %b/%0d want 1/5", realign, offset); end
    run_to(3);
    vectors++; if (realign !== 1'b0 || offset !== 5'd5 || aligned !== 1'b0) begin miscompares++; $display("FAIL restart_second_s3: got %b/%0d/%b want 0/5/0", realign, offset, aligned); end
    run_to(5);
    vectors++; if (realign !== 1'b1 || offset !== 5'd12 || aligned !== 1'b0) begin miscompares++; $display("FAIL restart_move_s5: got %b/%0d/%b want 1/12/0", realign, offset, aligned); end
    vectors++; if (outdata[9:0] !== K_NEG || comma !== 1'b1) begin miscompares++; $display("FAIL restart_aligned_word_s5: got %h/%b want 17c/1", outdata[9:0], comma); end
    run_to(9);
    vectors++; if (aligned !== 1'b0) begin miscompares++; $display("FAIL restart_verify_s9: got %b want 0", aligned); end
    run_to(11);
    vectors++; if (aligned !== 1'b1 || offset !== 5'd12) begin miscompares++; $display("FAIL restart_lock_s11: got %b/%0d want 1/12", aligned, offset); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_offset_wrap();
    test_false_comma();
    test_slip();
    test_reset_midlock();
    test_verify_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end want finish");
    $fatal(1, "watchdog");
  end

endmodule
